// File: rtl/pll_reset_sequencer.sv
// PLL reset driver and lock qualifier that releases staged per-domain resets in index order.
// Runs on the free-running reference clock and re-sequences on lock loss, timeout or sw_reset.
module pll_reset_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int STAGE_GAP      = 8,
    parameter int NUM_RST        = 3,
    parameter int CNT_W          = 8
) (
    input  logic               clkin,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               sw_reset,
    output logic               pll_rst,
    output logic [NUM_RST-1:0] rst_out_n,
    output logic               ready,
    output logic [CNT_W-1:0]   lock_loss_cnt,
    output logic [CNT_W-1:0]   timeout_cnt
);
    localparam int MAX_A   = (RST_CYCLES > STAGE_GAP) ? RST_CYCLES : STAGE_GAP;
    localparam int CNT_MAX = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [NUM_RST-1:0] FIRST_BIT = NUM_RST'(1);

    typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, RELEASE, RUN} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stable;
    logic          locked_s;
    logic          lock_lost;
    logic          stable_hit;
    logic          timed_out;
    logic          restart;

    assign locked_s   = sync[1];
    assign lock_lost  = (state == RELEASE || state == RUN) && !locked_s;
    assign stable_hit = (state == WAIT_LOCK) && locked_s && (stable == SW'(STABLE_CYCLES - 1));
    // Release wins over a timeout landing in the same cycle.
    assign timed_out  = (state == WAIT_LOCK) && !stable_hit && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign restart    = sw_reset || lock_lost || timed_out;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync          <= '0;
            state         <= RESET_PLL;
            cnt           <= '0;
            stable        <= '0;
            pll_rst       <= 1'b1;
            rst_out_n     <= '0;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            // NOTE: pll_locked is asynchronous and may glitch; nothing but the second flop is ever used.
            sync <= {sync[0], pll_locked};

            if (restart) begin
                state     <= RESET_PLL;
                cnt       <= '0;
                stable    <= '0;
                pll_rst   <= 1'b1;
                rst_out_n <= '0;
                ready     <= 1'b0;
                if (!sw_reset && lock_lost && lock_loss_cnt != '1)
                    lock_loss_cnt <= lock_loss_cnt + 1'b1;
                if (!sw_reset && timed_out && timeout_cnt != '1)
                    timeout_cnt <= timeout_cnt + 1'b1;
            end else begin
                case (state)
                    RESET_PLL: begin
                        if (cnt == CW'(RST_CYCLES - 1)) begin
                            state   <= WAIT_LOCK;
                            pll_rst <= 1'b0;
                            cnt     <= '0;
                            stable  <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (stable_hit) begin
                            state     <= RELEASE;
                            rst_out_n <= FIRST_BIT;
                            cnt       <= '0;
                        end else begin
                            cnt    <= cnt + 1'b1;
                            stable <= locked_s ? stable + 1'b1 : '0;
                        end
                    end
                    RELEASE: begin
                        if (&rst_out_n) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else if (cnt == CW'(STAGE_GAP - 1)) begin
                            // Thermometer shift keeps deassertion strictly in index order.
                            rst_out_n <= (rst_out_n << 1) | FIRST_BIT;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: directed and randomized lock/sw_reset stimulus against a phase/elapsed-time model.
module tb_pll_reset_sequencer;
    localparam int RST_CYCLES     = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int STAGE_GAP      = 2;
    localparam int NUM_RST        = 3;
    localparam int CNT_W          = 4;
    localparam int SAT            = (1 << CNT_W) - 1;
    localparam int M_RST = 0, M_WAIT = 1, M_REL = 2, M_RUN = 3;

    logic               clkin = 1'b0;
    logic               rst_n = 1'b0;
    logic               pll_locked = 1'b0;
    logic               sw_reset = 1'b0;
    logic               pll_rst;
    logic [NUM_RST-1:0] rst_out_n;
    logic               ready;
    logic [CNT_W-1:0]   lock_loss_cnt;
    logic [CNT_W-1:0]   timeout_cnt;

    pll_reset_sequencer #(
        .RST_CYCLES(RST_CYCLES), .STABLE_CYCLES(STABLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .STAGE_GAP(STAGE_GAP), .NUM_RST(NUM_RST), .CNT_W(CNT_W)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .pll_locked(pll_locked), .sw_reset(sw_reset),
        .pll_rst(pll_rst), .rst_out_n(rst_out_n), .ready(ready),
        .lock_loss_cnt(lock_loss_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clkin = ~clkin;

    int   checks = 0;
    int   failures = 0;
    int   m_phase, m_t, m_run, m_lost, m_to;
    logic m_s1, m_s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = M_RST; m_t = 0; m_run = 0; m_lost = 0; m_to = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs held across that edge.
    task automatic model_edge();
        logic ls;
        ls = m_s2; m_s2 = m_s1; m_s1 = pll_locked;
        if (sw_reset) begin
            m_phase = M_RST; m_t = 0;
        end else begin
            case (m_phase)
                M_RST: begin
                    if (m_t + 1 == RST_CYCLES) begin m_phase = M_WAIT; m_t = 0; m_run = 0; end
                    else m_t++;
                end
                M_WAIT: begin
                    m_run = ls ? m_run + 1 : 0;
                    if (m_run >= STABLE_CYCLES) begin m_phase = M_REL; m_t = 0; end
                    else if (m_t + 1 >= TIMEOUT_CYCLES) begin m_phase = M_RST; m_t = 0; m_to++; end
                    else m_t++;
                end
                M_REL: begin
                    if (!ls) begin m_phase = M_RST; m_t = 0; m_lost++; end
                    else if (m_t >= (NUM_RST - 1) * STAGE_GAP) m_phase = M_RUN;
                    else m_t++;
                end
                default: begin
                    if (!ls) begin m_phase = M_RST; m_t = 0; m_lost++; end
                end
            endcase
        end
    endtask

    task automatic check_all(input string where);
        int          n;
        logic [31:0] therm;
        if (m_phase == M_RUN) n = NUM_RST;
        else if (m_phase == M_REL) n = (m_t / STAGE_GAP + 1 > NUM_RST) ? NUM_RST : m_t / STAGE_GAP + 1;
        else n = 0;
        therm = (32'd1 << n) - 32'd1;
        check({where, ".pll_rst"}, pll_rst, m_phase == M_RST);
        check({where, ".rst_out_n"}, rst_out_n, therm);
        check({where, ".ready"}, ready, m_phase == M_RUN);
        check({where, ".lock_loss_cnt"}, lock_loss_cnt, (m_lost > SAT) ? SAT : m_lost);
        check({where, ".timeout_cnt"}, timeout_cnt, (m_to > SAT) ? SAT : m_to);
    endtask

    task automatic step(input logic lk, input logic sw, input string where);
        pll_locked = lk;
        sw_reset   = sw;
        @(posedge clkin);
        model_edge();
        #1 check_all(where);
    endtask

    initial begin
        int   saved_lost;
        int   hold;
        logic lk;
        logic found;

        model_reset();
        pll_locked = 1'b1;
        repeat (3) @(posedge clkin);
        #1 check_all("reset");
        rst_n = 1'b1;

        repeat (30) step(1'b1, 1'b0, "powerup");
        check("powerup_ready", ready, 1);

        repeat (121) step(1'b0, 1'b0, "nolock");
        check("nolock_timeouts", timeout_cnt, 3);

        repeat (60) step(1'b1, 1'b0, "relock");
        check("relock_ready", ready, 1);
        step(1'b0, 1'b0, "drop");
        step(1'b1, 1'b0, "drop");
        step(1'b1, 1'b0, "drop");
        check("drop_ready", ready, 0);
        check("drop_pll_rst", pll_rst, 1);
        check("drop_loss", lock_loss_cnt, 2);
        repeat (30) step(1'b1, 1'b0, "rerun");
        check("rerun_ready", ready, 1);

        // Lock toggling every 5 cycles can never satisfy the stability window.
        step(1'b1, 1'b1, "toggle_sw");
        for (int i = 0; i < 64; i++) begin
            step(((i / 5) % 2) != 0, 1'b0, "toggle");
            check("toggle_no_release", rst_out_n, 0);
        end
        check("toggle_timeout", timeout_cnt, 4);

        repeat (60) step(1'b1, 1'b0, "to_run");
        check("to_run_ready", ready, 1);
        saved_lost = m_lost;
        step(1'b0, 1'b0, "sw_vs_loss");
        step(1'b0, 1'b0, "sw_vs_loss");
        step(1'b0, 1'b1, "sw_vs_loss");
        check("sw_vs_loss_cnt", lock_loss_cnt, saved_lost);
        check("sw_vs_loss_rst", rst_out_n, 0);

        for (int i = 0; i < 300; i += hold) begin
            hold = $urandom_range(1, 20);
            lk   = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < hold; j++)
                step(lk, $urandom_range(0, 49) == 0, "random");
        end

        for (int k = 0; k < 20; k++) begin
            repeat (25) step(1'b1, 1'b0, "sat");
            step(1'b0, 1'b0, "sat_drop");
        end
        repeat (3) step(1'b1, 1'b0, "sat");
        check("sat_lock_loss", lock_loss_cnt, 15);

        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(1'b1, 1'b0, "to_release");
            if (m_phase == M_REL && m_t == 2) found = 1'b1;
        end
        check("reached_release", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_pll_rst", pll_rst, 1);
        check("async_rst_out_n", rst_out_n, 0);
        check("async_ready", ready, 0);
        check("async_lock_loss", lock_loss_cnt, 0);
        check("async_timeout", timeout_cnt, 0);
        model_reset();
        @(posedge clkin);
        #1 check_all("held_reset");
        rst_n = 1'b1;
        repeat (30) step(1'b1, 1'b0, "after_reset");
        check("after_reset_ready", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
